// File: rtl/swiss_timer_sequencer.sv
// Stopwatch control sequencer: debounced buttons drive an IDLE/RUN/PAUSE/LAP FSM
// and a prescaler that emits one-cycle count ticks to the timer datapath.

module swiss_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1, r_sync2;
    logic          r_lvl, r_lvl_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_lvl_d <= r_lvl;
            // Any cycle agreeing with the accepted level restarts the stability count.
            if (r_sync2 != r_lvl) begin
                if (r_cnt == CNT_LAST) begin
                    r_lvl <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_lvl & ~r_lvl_d;
endmodule

module swiss_timer_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_DIV        = 1000000
) (
    input  logic       clock100MHz,
    input  logic       reset,
    input  logic       start_Button,
    input  logic       left_Button,
    input  logic       right_Button,
    input  logic       down_Button,
    input  logic       clear_Button,
    output logic       count_Enable,
    output logic       count_Clear,
    output logic       display_Hold,
    output logic [1:0] state
);
    localparam int NUM_BTN = 5;
    localparam int B_START = 0;
    localparam int B_LEFT  = 1;
    localparam int B_RIGHT = 2;
    localparam int B_DOWN  = 3;
    localparam int B_CLEAR = 4;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] LAP   = 2'b11;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_press;

    assign w_raw = {clear_Button, down_Button, right_Button, left_Button, start_Button};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        swiss_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .i_clk  (clock100MHz),
            .i_rst  (reset),
            .i_raw  (w_raw[g]),
            .o_press(w_press[g])
        );
    end

    logic          w_clr, w_start, w_pause, w_lap, w_active;
    logic [1:0]    w_state_nxt;
    logic [1:0]    r_state;
    logic [PW-1:0] r_psc;
    logic          r_ce, r_clr;

    assign w_clr    = w_press[B_CLEAR];
    assign w_start  = w_press[B_START];
    assign w_pause  = w_press[B_LEFT] | w_press[B_RIGHT];
    assign w_lap    = w_press[B_DOWN];
    assign w_active = (r_state == RUN) || (r_state == LAP);

    // Only the highest-priority event is considered; an ignored one still masks the rest.
    always_comb begin
        w_state_nxt = r_state;
        if (w_clr) begin
            w_state_nxt = IDLE;
        end else if (w_start) begin
            if (r_state != RUN) w_state_nxt = RUN;
        end else if (w_pause) begin
            if (w_active) w_state_nxt = PAUSE;
        end else if (w_lap) begin
            if (r_state == RUN)      w_state_nxt = LAP;
            else if (r_state == LAP) w_state_nxt = RUN;
        end
    end

    always_ff @(posedge clock100MHz or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_psc   <= '0;
            r_ce    <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_clr   <= w_clr;
            // Tick decision uses the current state, so a terminal cycle that
            // coincides with a pause still issues its tick.
            r_ce    <= w_active && (r_psc == PSC_LAST) && !r_ce;
            if (w_clr || r_state == IDLE) begin
                r_psc <= '0;
            end else if (w_active) begin
                r_psc <= (r_psc == PSC_LAST) ? '0 : r_psc + 1'b1;
            end
        end
    end

    assign count_Enable = r_ce;
    assign count_Clear  = r_clr;
    assign display_Hold = (r_state == LAP);
    assign state        = r_state;
endmodule

// File: tb/tb_swiss_timer_sequencer.sv
// Scoreboard bench: expected tick/clear cycles are queued from the stimulus
// timeline and matched against DUT pulses as they appear.

module tb_swiss_timer_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_b = 1'b0, left_b = 1'b0, right_b = 1'b0, down_b = 1'b0, clear_b = 1'b0;
    logic       count_Enable, count_Clear, display_Hold;
    logic [1:0] state;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int tick_q[$];
    int clr_q[$];
    logic prev_ce = 1'b0;

    swiss_timer_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV       (10)
    ) dut (
        .clock100MHz (clk),
        .reset       (reset),
        .start_Button(start_b),
        .left_Button (left_b),
        .right_Button(right_b),
        .down_Button (down_b),
        .clear_Button(clear_b),
        .count_Enable(count_Enable),
        .count_Clear (count_Clear),
        .display_Hold(display_Hold),
        .state       (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Pulse monitor: every DUT pulse must match the head of its queue.
    always @(negedge clk) begin
        if (tick_q.size() > 0 && cyc > tick_q[0]) begin
            chk("tick_missed", cyc, tick_q[0]);
            void'(tick_q.pop_front());
        end
        if (clr_q.size() > 0 && cyc > clr_q[0]) begin
            chk("clr_missed", cyc, clr_q[0]);
            void'(clr_q.pop_front());
        end
        if (count_Enable) begin
            chk("tick_single", int'(prev_ce), 0);
            if (tick_q.size() == 0) chk("tick_unexp", cyc, -1);
            else                    chk("tick_cyc", cyc, tick_q.pop_front());
        end
        if (count_Clear) begin
            if (clr_q.size() == 0) chk("clr_unexp", cyc, -1);
            else                   chk("clr_cyc", cyc, clr_q.pop_front());
        end
        prev_ce <= count_Enable;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, r, p, r2, l, u, p2, c, kr;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_ce", int'(count_Enable), 0);
        chk("rst_clr", int'(count_Clear), 0);
        chk("rst_hold", int'(display_Hold), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_state", int'(state), 0);

        // Short glitches must never be accepted
        for (int rep = 0; rep < 3; rep++) begin
            for (int w = 1; w <= 3; w++) begin
                start_b = 1'b1;
                repeat (w) @(negedge clk);
                start_b = 1'b0;
                repeat (4) @(negedge clk);
            end
        end
        repeat (4) @(negedge clk);
        chk("glitch_state", int'(state), 0);

        // Start: 2 sync + 4 debounce + 1 state register = 7 cycles
        k = cyc; start_b = 1'b1; r = k + 7;
        tick_q.push_back(r + 10); tick_q.push_back(r + 20); tick_q.push_back(r + 30);
        wait_until(r - 1); chk("pre_run_state", int'(state), 0);
        wait_until(r);     chk("run_state", int'(state), 1);
        wait_until(k + 20); start_b = 1'b0;

        // Pause 5 cycles into a tick period; prescaler holds 5
        wait_until(r + 28); left_b = 1'b1; p = r + 35;
        wait_until(p); chk("pause_state", int'(state), 2);
        chk("pause_hold", int'(display_Hold), 0);
        wait_until(r + 40); left_b = 1'b0;

        // Resume: first tick after the 5 remaining prescaler cycles
        wait_until(p + 20); start_b = 1'b1; r2 = p + 27;
        tick_q.push_back(r2 + 5); tick_q.push_back(r2 + 15);
        tick_q.push_back(r2 + 25); tick_q.push_back(r2 + 35);
        wait_until(r2); chk("resume_state", int'(state), 1);
        wait_until(p + 32); start_b = 1'b0;

        // Lap toggles with ticks continuing
        wait_until(r2 + 10); down_b = 1'b1; l = r2 + 17;
        wait_until(l); chk("lap_state", int'(state), 3);
        chk("lap_hold", int'(display_Hold), 1);
        wait_until(r2 + 20); down_b = 1'b0;
        wait_until(r2 + 30); down_b = 1'b1; u = r2 + 37;
        wait_until(u - 1); chk("lap_still", int'(state), 3);
        wait_until(u); chk("unlap_state", int'(state), 1);
        chk("unlap_hold", int'(display_Hold), 0);

        // Pause landing on a terminal cycle still issues that tick
        wait_until(r2 + 38); left_b = 1'b1; p2 = r2 + 45;
        tick_q.push_back(r2 + 45);
        wait_until(r2 + 40); down_b = 1'b0;
        wait_until(p2); chk("pause2_state", int'(state), 2);
        wait_until(r2 + 50); left_b = 1'b0;

        // Clear and start together: clear wins
        wait_until(p2 + 15); start_b = 1'b1; clear_b = 1'b1; c = p2 + 22;
        clr_q.push_back(c);
        wait_until(c - 1); chk("pre_clr", int'(count_Clear), 0);
        wait_until(c); chk("clr_state", int'(state), 0);
        chk("clr_pulse", int'(count_Clear), 1);
        wait_until(c + 1); chk("clr_one", int'(count_Clear), 0);
        wait_until(p2 + 30); start_b = 1'b0; clear_b = 1'b0;
        wait_until(c + 30); chk("clr_idle", int'(state), 0);

        // Reset mid-RUN, between clock edges
        k = cyc; start_b = 1'b1; r = k + 7;
        tick_q.push_back(r + 10);
        wait_until(r + 13);
        chk("run2_state", int'(state), 1);
        tick_q.delete();
        #2 reset = 1'b1;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_ce", int'(count_Enable), 0);
        chk("arst_clr", int'(count_Clear), 0);
        chk("arst_hold", int'(display_Hold), 0);
        repeat (3) @(negedge clk);
        chk("rst_hold_state", int'(state), 0);
        // Button still held through reset: one press after debounce
        kr = cyc; reset = 1'b0;
        tick_q.push_back(kr + 17);
        wait_until(kr + 6); chk("held_pre", int'(state), 0);
        wait_until(kr + 7); chk("held_run", int'(state), 1);
        wait_until(kr + 22);
        start_b = 1'b0;
        @(negedge clk);
        chk("tick_q_empty", tick_q.size(), 0);
        chk("clr_q_empty", clr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/swiss_timer_sequencer.md
SWISS_TIMER_SEQUENCER -- requirements
Module: swiss_timer_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable clock cycles (5 ms at 100 MHz) before a button level is accepted.
REQ-002 SHALL have parameter TICK_DIV, default 1000000, meaning 100 MHz cycles per count tick (10 ms).
REQ-003 SHALL have port clock100MHz, input, 1 bit: sole clock, all flops on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-005 SHALL have port start_Button, input, 1 bit: raw asynchronous start/resume button.
REQ-006 SHALL have ports left_Button and right_Button, input, 1 bit each: raw pause buttons, ORed after debounce.
REQ-007 SHALL have port down_Button, input, 1 bit: raw lap toggle button.
REQ-008 SHALL have port clear_Button, input, 1 bit: raw clear button.
REQ-009 SHALL have port count_Enable, output, 1 bit: one-cycle count tick to the timer datapath.
REQ-010 SHALL have port count_Clear, output, 1 bit: one-cycle datapath clear pulse.
REQ-011 SHALL have port display_Hold, output, 1 bit: freeze display (lap).
REQ-012 SHALL have port state, output, 2 bits: current state code.

Function
REQ-013 SHALL pass each raw button through a 2-flop synchronizer before any other use.
REQ-014 SHALL debounce each synchronized button with its own counter: it counts cycles where the synchronized level differs from the accepted level; any matching cycle zeroes it; on reaching DEBOUNCE_CYCLES it updates the accepted level and zeroes.
REQ-015 SHALL generate a one-cycle press event on each 0->1 transition of an accepted level; releases generate no event.
REQ-016 SHALL encode states IDLE=00, RUN=01, PAUSE=10, LAP=11; the state register updates on the cycle after the press event.
REQ-017 SHALL apply events in priority order clear > start > pause > lap when several coincide; lower-priority events in that cycle are discarded.
REQ-018 Clear: any state -> IDLE; count_Clear high exactly one cycle; prescaler zeroed; display_Hold 0.
REQ-019 Start: IDLE, PAUSE or LAP -> RUN; in RUN ignored.
REQ-020 Pause (left or right): RUN or LAP -> PAUSE; ignored in IDLE and PAUSE.
REQ-021 Lap: RUN -> LAP, LAP -> RUN; ignored in IDLE and PAUSE.
REQ-022 display_Hold SHALL be 1 exactly while state is LAP.
REQ-023 Prescaler, range 0..TICK_DIV-1, width ceil(log2(TICK_DIV)): increments in RUN and LAP, holds in PAUSE, held at 0 in IDLE; wraps TICK_DIV-1 -> 0.
REQ-024 count_Enable SHALL be a registered pulse high for the one cycle after a cycle in which state is RUN or LAP and the prescaler equals TICK_DIV-1; never high for two consecutive cycles.
REQ-025 A tick whose terminal cycle coincides with a pause transition SHALL still be issued.
REQ-026 Resume from PAUSE SHALL continue the held prescaler value, so elapsed run time is conserved to one clock.
REQ-027 Held buttons SHALL produce exactly one event regardless of hold duration.

Reset
REQ-028 Asserting reset SHALL immediately, without a clock edge, force state=IDLE, count_Enable=0, count_Clear=0, display_Hold=0, prescaler=0, all debounce counters 0, accepted levels 0, synchronizers 0.
REQ-029 After reset deassertion, a button already held high SHALL produce one press event after debounce.
REQ-030 Reset SHALL NOT itself cause a count_Clear pulse.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=10)
REQ-031 Reset, hold start_Button 20 cycles -> state 01 within 4..8 cycles of the press; count_Enable one-cycle pulses exactly every 10 cycles.
REQ-032 start_Button glitches of 1-3 cycles, repeated -> state remains 00; no count_Enable.
REQ-033 RUN 15 cycles past a tick, press left_Button -> state 10, no count_Enable while paused; press start_Button -> state 01, first tick after the remaining prescaler cycles, not a full 10.
REQ-034 In RUN press down_Button -> state 11, display_Hold 1, ticks continue every 10 cycles; press again -> state 01, display_Hold 0.
REQ-035 start_Button and clear_Button rise together in PAUSE -> state 00, count_Clear high exactly 1 cycle, no count_Enable afterwards.
REQ-036 Assert reset mid-RUN between clock edges -> all outputs 0 and state 00 before the next clock edge; hold reset 3 cycles -> no pulses.
